// File: rtl/mips_isa_pkg.sv
// MIPS ISA constants shared by the encoder and the main/ALU decoders.
// Opcodes, functs, ALU control codes, request classes and the NOP word.
package mips_isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [2:0] KIND_RTYPE = 3'd0;
    localparam logic [2:0] KIND_LW    = 3'd1;
    localparam logic [2:0] KIND_SW    = 3'd2;
    localparam logic [2:0] KIND_BEQ   = 3'd3;
    localparam logic [2:0] KIND_ADDI  = 3'd4;
    localparam logic [2:0] KIND_J     = 3'd5;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef struct packed {
        logic        err;
        logic [31:0] word;
    } enc_t;

endpackage

// File: rtl/mips_instr_encoder_if.sv
// Request and response valid/ready streams of the instruction encoder.
// master drives requests and consumes words; slave is the encoder.
interface mips_instr_encoder_if;

    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_kind;
    logic [2:0]  in_alu;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;

    modport master (
        output in_valid, in_kind, in_alu, in_rs, in_rt,
        output in_rd, in_imm, in_target, out_ready,
        input  in_ready, out_valid, out_instr, out_err
    );

    modport slave (
        input  in_valid, in_kind, in_alu, in_rs, in_rt,
        input  in_rd, in_imm, in_target, out_ready,
        output in_ready, out_valid, out_instr, out_err
    );

endinterface

// File: rtl/mips_instr_encoder_fifo.sv
// Synchronous circular-buffer FIFO, pointers one bit wider than the
// index so full and empty are distinguishable; push+pop legal when full.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Empty head reads as zero so a flushed FIFO shows a NOP word.
    assign data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/mips_instr_encoder.sv
// Builds MIPS instruction words from class/ALU code/fields, registers them
// once and buffers them in an output FIFO; illegal requests become NOP+err.
module mips_instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    mips_instr_encoder_if.slave  bus,
    output logic [CNT_W-1:0]     cnt_instr,
    output logic [CNT_W-1:0]     cnt_err
);

    enc_t             enc;
    enc_t             s1_q, s1_d;
    enc_t             head;
    logic             s1_valid_q, s1_valid_d;
    logic             s1_move;
    logic             accept;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic [5:0]       funct;
    logic [CNT_W-1:0] cnt_instr_q, cnt_instr_d;
    logic [CNT_W-1:0] cnt_err_q, cnt_err_d;

    always_comb begin
        enc.word = NOP;
        enc.err  = 1'b0;
        funct    = FN_ADD;
        case (bus.in_kind)
            KIND_RTYPE: begin
                case (bus.in_alu)
                    ALU_ADD: funct = FN_ADD;
                    ALU_SUB: funct = FN_SUB;
                    ALU_AND: funct = FN_AND;
                    ALU_OR:  funct = FN_OR;
                    ALU_SLT: funct = FN_SLT;
                    default: enc.err = 1'b1;
                endcase
                if (!enc.err) begin
                    enc.word = {OP_RTYPE, bus.in_rs, bus.in_rt,
                                bus.in_rd, 5'b00000, funct};
                end
            end
            KIND_LW:   enc.word = {OP_LW, bus.in_rs, bus.in_rt, bus.in_imm};
            KIND_SW:   enc.word = {OP_SW, bus.in_rs, bus.in_rt, bus.in_imm};
            KIND_BEQ:  enc.word = {OP_BEQ, bus.in_rs, bus.in_rt, bus.in_imm};
            KIND_ADDI: enc.word = {OP_ADDI, bus.in_rs, bus.in_rt, bus.in_imm};
            KIND_J:    enc.word = {OP_J, bus.in_target};
            default:   enc.err = 1'b1;
        endcase
    end

    assign pop          = !fifo_empty && bus.out_ready;
    assign s1_move      = s1_valid_q && (!fifo_full || pop);
    // Ready is a function of stage state only, never of in_valid.
    assign bus.in_ready = reset_n && (!s1_valid_q || s1_move);
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_d        = s1_q;
        cnt_instr_d = cnt_instr_q;
        cnt_err_d   = cnt_err_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_d       = enc;
            if (enc.err) begin
                if (cnt_err_q != '1) cnt_err_d = cnt_err_q + CNT_W'(1);
            end else begin
                if (cnt_instr_q != '1) cnt_instr_d = cnt_instr_q + CNT_W'(1);
            end
        end else if (s1_move) begin
            s1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            cnt_instr_q <= '0;
            cnt_err_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_q        <= s1_d;
            cnt_instr_q <= cnt_instr_d;
            cnt_err_q   <= cnt_err_d;
        end
    end

    sync_fifo #(
        .WIDTH (33),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .push_i  (s1_move),
        .data_i  (s1_q),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.out_valid = !fifo_empty;
    assign bus.out_instr = head.word;
    assign bus.out_err   = head.err;
    assign cnt_instr     = cnt_instr_q;
    assign cnt_err       = cnt_err_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Bench for mips_instr_encoder: vector table, corner sequences and
// random traffic against a queue-based reference model.
module tb_mips_instr_encoder;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    typedef struct {
        logic        v;
        logic [2:0]  kind;
        logic [2:0]  alu;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [25:0] tg;
    } req_t;

    typedef struct {
        req_t        r;
        logic [31:0] w;
        logic        e;
    } vec_t;

    typedef struct {
        logic [31:0] w;
        logic        e;
        logic [2:0]  kind;
        logic [2:0]  alu;
        longint      stamp;
    } sb_t;

    logic clock;
    logic reset_n;
    logic [CNT_W-1:0] cnt_instr;
    logic [CNT_W-1:0] cnt_err;

    mips_instr_encoder_if bus ();

    mips_instr_encoder #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus),
        .cnt_instr (cnt_instr),
        .cnt_err   (cnt_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int     total = 0;
    int     bad = 0;
    longint cyc = 0;
    logic   rst_drv = 1'b1;
    sb_t    q[$];
    int     m_ci = 0;
    int     m_ce = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_enc(input req_t r, output logic [31:0] w,
                                    output logic e);
        longint x;
        int fn;
        int op;
        e = 1'b0;
        x = 0;
        fn = -1;
        op = -1;
        case (r.kind)
            3'd0: begin
                case (r.alu)
                    3'b010: fn = 32;
                    3'b110: fn = 34;
                    3'b000: fn = 36;
                    3'b001: fn = 37;
                    3'b111: fn = 42;
                    default: fn = -1;
                endcase
                if (fn < 0) e = 1'b1;
                else x = longint'(r.rs) * (2 ** 21) + longint'(r.rt) * (2 ** 16)
                       + longint'(r.rd) * (2 ** 11) + fn;
            end
            3'd1: op = 35;
            3'd2: op = 43;
            3'd3: op = 4;
            3'd4: op = 8;
            3'd5: x = 2 * longint'(2 ** 26) + longint'(r.tg);
            default: e = 1'b1;
        endcase
        if (op >= 0)
            x = longint'(op) * (2 ** 26) + longint'(r.rs) * (2 ** 21)
              + longint'(r.rt) * (2 ** 16) + longint'(r.imm);
        w = x[31:0];
    endfunction

    function automatic logic [2:0] maindec(input logic [5:0] op);
        case (op)
            6'd0:  return 3'd0;
            6'd35: return 3'd1;
            6'd43: return 3'd2;
            6'd4:  return 3'd3;
            6'd8:  return 3'd4;
            6'd2:  return 3'd5;
            default: return 3'd7;
        endcase
    endfunction

    function automatic logic [2:0] aludec(input logic [5:0] fn);
        case (fn)
            6'd32: return 3'b010;
            6'd34: return 3'b110;
            6'd36: return 3'b000;
            6'd37: return 3'b001;
            6'd42: return 3'b111;
            default: return 3'b011;
        endcase
    endfunction

    task automatic step(input req_t r, input logic ordy, input logic [31:0] ew,
                        input logic ee, output logic acc);
        logic exp_ov;
        logic exp_ir;
        sb_t  s;
        @(negedge clock);
        reset_n       = rst_drv;
        bus.in_valid  = r.v;
        bus.in_kind   = r.kind;
        bus.in_alu    = r.alu;
        bus.in_rs     = r.rs;
        bus.in_rt     = r.rt;
        bus.in_rd     = r.rd;
        bus.in_imm    = r.imm;
        bus.in_target = r.tg;
        bus.out_ready = ordy;
        #1;
        exp_ov = (q.size() > 0) && (q[0].stamp < cyc);
        exp_ir = rst_drv && ((q.size() < DEPTH + 1) || (exp_ov && ordy));
        chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
        chk("in_ready", 32'(bus.in_ready), 32'(exp_ir));
        chk("cnt_instr", 32'(cnt_instr), 32'(m_ci));
        chk("cnt_err", 32'(cnt_err), 32'(m_ce));
        if (exp_ov) begin
            chk("out_instr", bus.out_instr, q[0].w);
            chk("out_err", 32'(bus.out_err), 32'(q[0].e));
            if (!q[0].e) begin
                chk("maindec", 32'(maindec(bus.out_instr[31:26])), 32'(q[0].kind));
                if (q[0].kind == 3'd0)
                    chk("aludec", 32'(aludec(bus.out_instr[5:0])), 32'(q[0].alu));
            end
        end
        acc = 1'b0;
        if (!rst_drv) begin
            q.delete();
            m_ci = 0;
            m_ce = 0;
        end else begin
            if (exp_ov && ordy) void'(q.pop_front());
            acc = r.v && exp_ir;
            if (acc) begin
                s.w = ew;
                s.e = ee;
                s.kind = r.kind;
                s.alu = r.alu;
                s.stamp = cyc + 1;
                q.push_back(s);
                if (ee) m_ce = (m_ce == 65535) ? m_ce : m_ce + 1;
                else    m_ci = (m_ci == 65535) ? m_ci : m_ci + 1;
            end
        end
        @(posedge clock);
        cyc++;
    endtask

    function automatic req_t mk(input logic [2:0] k, input logic [2:0] a,
                                input int rs, input int rt, input int rd,
                                input int imm, input int tg);
        req_t r;
        r.v = 1'b1;
        r.kind = k;
        r.alu = a;
        r.rs = 5'(rs);
        r.rt = 5'(rt);
        r.rd = 5'(rd);
        r.imm = 16'(imm);
        r.tg = 26'(tg);
        return r;
    endfunction

    task automatic idle(input int n, input logic ordy);
        req_t r;
        logic a;
        r = mk(0, 0, 0, 0, 0, 0, 0);
        r.v = 1'b0;
        for (int i = 0; i < n; i++) step(r, ordy, 32'h0, 1'b0, a);
    endtask

    vec_t tbl[8];
    req_t burst[8];

    initial begin
        logic        a;
        logic [31:0] w;
        logic        e;
        int          n;
        int          idx;
        req_t        r;

        tbl[0] = '{mk(0, 3'b010, 1, 2, 3, 0, 0), 32'h00221820, 1'b0};
        tbl[1] = '{mk(1, 3'b101, 0, 8, 0, 16'h0004, 0), 32'h8C080004, 1'b0};
        tbl[2] = '{mk(2, 3'b000, 0, 8, 0, 16'h0004, 0), 32'hAC080004, 1'b0};
        tbl[3] = '{mk(3, 3'b011, 1, 2, 0, 16'hFFFF, 0), 32'h1022FFFF, 1'b0};
        tbl[4] = '{mk(4, 3'b010, 0, 9, 7, 5, 0), 32'h20090005, 1'b0};
        tbl[5] = '{mk(5, 3'b110, 3, 3, 3, 0, 26'h0000010), 32'h08000010, 1'b0};
        tbl[6] = '{mk(7, 3'b010, 1, 2, 3, 9, 9), 32'h0, 1'b1};
        tbl[7] = '{mk(0, 3'b011, 1, 2, 3, 0, 0), 32'h0, 1'b1};

        reset_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_kind = '0;
        bus.in_alu = '0;
        bus.in_rs = '0;
        bus.in_rt = '0;
        bus.in_rd = '0;
        bus.in_imm = '0;
        bus.in_target = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_out_instr", bus.out_instr, 32'h0);
        chk("rst_out_err", 32'(bus.out_err), 32'h0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
        @(posedge clock);
        cyc = 0;

        // table vectors, back to back
        idle(1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].r, 1'b1, tbl[i].w, tbl[i].e, a);
            chk("tbl_accept", 32'(a), 32'h1);
        end
        idle(4, 1'b1);
        chk("tbl_cnt_instr", 32'(cnt_instr), 32'd6);
        chk("tbl_cnt_err", 32'(cnt_err), 32'd2);

        // back-pressure: DEPTH+1 accepted, then release
        for (int i = 0; i < 8; i++)
            burst[i] = mk(4, 0, i, i + 1, 0, 100 + i, 0);
        n = 0;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            ref_enc(burst[idx], w, e);
            step(burst[idx], 1'b0, w, e, a);
            if (a) begin
                n++;
                if (idx < 7) idx++;
            end
        end
        chk("bp_accepted", 32'(n), 32'(DEPTH + 1));
        for (int c = 0; c < 20 && n < 8; c++) begin
            ref_enc(burst[idx], w, e);
            step(burst[idx], 1'b1, w, e, a);
            if (a) begin
                n++;
                if (idx < 7) idx++;
            end
        end
        chk("bp_all_in", 32'(n), 32'd8);
        idle(8, 1'b1);

        // reset with FIFO half full
        for (int i = 0; i < 2; i++) begin
            ref_enc(burst[i], w, e);
            step(burst[i], 1'b0, w, e, a);
        end
        idle(2, 1'b0);
        rst_drv = 1'b0;
        idle(1, 1'b0);
        rst_drv = 1'b1;
        idle(1, 1'b1);
        chk("mid_rst_instr", bus.out_instr, 32'h0);
        r = mk(3, 0, 4, 5, 0, 16'h8000, 0);
        ref_enc(r, w, e);
        step(r, 1'b1, w, e, a);
        idle(3, 1'b1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            r.v = ($urandom_range(0, 3) != 0);
            r.kind = 3'($urandom_range(0, 7));
            r.alu = 3'($urandom);
            r.rs = 5'($urandom);
            r.rt = 5'($urandom);
            r.rd = 5'($urandom);
            r.imm = 16'($urandom);
            r.tg = 26'($urandom);
            ref_enc(r, w, e);
            step(r, ($urandom_range(0, 9) < 7), w, e, a);
        end
        idle(8, 1'b1);

        // counter saturation
        rst_drv = 1'b0;
        idle(1, 1'b1);
        rst_drv = 1'b1;
        r = mk(4, 0, 1, 2, 0, 3, 0);
        ref_enc(r, w, e);
        for (int i = 0; i < 65540; i++) step(r, 1'b1, w, e, a);
        idle(4, 1'b1);
        chk("sat_cnt_instr", 32'(cnt_instr), 32'h0000FFFF);
        chk("sat_cnt_err", 32'(cnt_err), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
